// File: rtl/game_round_pkg.sv
// Shared types and defaults for the target/torpedo round sequencer.
package game_round_pkg;

  localparam int unsigned N_SHOTS_DEF     = 3;
  localparam int unsigned SHOT_WIDTH_DEF  = 3;
  localparam int unsigned SCORE_WIDTH_DEF = 8;

  // Round sequencer states, 3-bit binary encoding.
  typedef enum logic [2:0] {
    S_START      = 3'd0,
    S_TGT_SETTLE = 3'd1,
    S_FLY        = 3'd2,
    S_TOR_SETTLE = 3'd3,
    S_SHOT       = 3'd4,
    S_END_START  = 3'd5,
    S_END_WAIT   = 3'd6
  } state_t;

endpackage

// File: rtl/game_round_controller_key_edge.sv
// Fire-button conditioner: 2-flop synchronizer followed by a rising-edge
// detector. One o_fire cycle per press; a held key never repeats.
module game_key_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic i_key,
  output logic o_fire
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;

  // Synchronize the asynchronous key and keep its previous synchronized value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= i_key;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign o_fire = r_sync2 & ~r_prev;

endmodule

// File: rtl/game_round_controller.sv
// Master sequencer for the target/torpedo game: launches the target, fires
// torpedoes on key presses, scores hits and runs the end-of-round timer.
// Every output is a register that reflects what the state did on the
// previous clock, so write pulses and enables of a sprite never overlap.
module game_round_controller
  import game_round_pkg::*;
#(
  parameter int unsigned N_SHOTS     = N_SHOTS_DEF,
  parameter int unsigned SHOT_WIDTH  = SHOT_WIDTH_DEF,
  parameter int unsigned SCORE_WIDTH = SCORE_WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   key,
  output logic                   sprite_target_write_xy,
  output logic                   sprite_target_write_dxy,
  output logic                   sprite_target_enable_update,
  output logic                   sprite_torpedo_write_xy,
  output logic                   sprite_torpedo_write_dxy,
  output logic                   sprite_torpedo_enable_update,
  input  logic                   sprite_target_within_screen,
  input  logic                   sprite_torpedo_within_screen,
  input  logic                   collision,
  output logic                   game_won,
  output logic                   end_of_game_timer_start,
  input  logic                   end_of_game_timer_running,
  output logic [SHOT_WIDTH-1:0]  shots_left,
  output logic [SCORE_WIDTH-1:0] score
);

  state_t                 r_state;
  logic                   r_tgt_wxy;
  logic                   r_tgt_wdxy;
  logic                   r_tgt_en;
  logic                   r_tor_wxy;
  logic                   r_tor_wdxy;
  logic                   r_tor_en;
  logic                   r_won;
  logic                   r_timer_start;
  logic [SHOT_WIDTH-1:0]  r_shots;
  logic [SCORE_WIDTH-1:0] r_score;
  logic                   r_seen_run;
  logic                   r_idle_once;
  logic                   w_fire;

  game_key_edge u_key_edge (
    .clk    (clk),
    .rst_n  (reset),
    .i_key  (key),
    .o_fire (w_fire)
  );

  // Round sequencer with registered pulse, enable, score and shot outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_START;
      r_tgt_wxy     <= 1'b0;
      r_tgt_wdxy    <= 1'b0;
      r_tgt_en      <= 1'b0;
      r_tor_wxy     <= 1'b0;
      r_tor_wdxy    <= 1'b0;
      r_tor_en      <= 1'b0;
      r_won         <= 1'b0;
      r_timer_start <= 1'b0;
      r_shots       <= '0;
      r_score       <= '0;
      r_seen_run    <= 1'b0;
      r_idle_once   <= 1'b0;
    end else begin
      r_tgt_wxy     <= 1'b0;
      r_tgt_wdxy    <= 1'b0;
      r_tor_wxy     <= 1'b0;
      r_tor_wdxy    <= 1'b0;
      r_timer_start <= 1'b0;
      case (r_state)
        S_START: begin
          r_tgt_wxy  <= 1'b1;
          r_tgt_wdxy <= 1'b1;
          r_tgt_en   <= 1'b0;
          r_tor_en   <= 1'b0;
          r_shots    <= SHOT_WIDTH'(N_SHOTS);
          r_won      <= 1'b0;
          r_state    <= S_TGT_SETTLE;
        end
        S_TGT_SETTLE: begin
          r_tgt_en <= 1'b0;
          r_tor_en <= 1'b0;
          r_state  <= S_FLY;
        end
        S_FLY: begin
          r_tgt_en <= 1'b1;
          r_tor_en <= 1'b0;
          if (!sprite_target_within_screen) begin
            r_state <= S_END_START;
          end else if (w_fire && (r_shots != '0)) begin
            r_tor_wxy  <= 1'b1;
            r_tor_wdxy <= 1'b1;
            r_shots    <= r_shots - SHOT_WIDTH'(1);
            r_state    <= S_TOR_SETTLE;
          end
        end
        S_TOR_SETTLE: begin
          r_tgt_en <= 1'b1;
          r_tor_en <= 1'b0;
          r_state  <= S_SHOT;
        end
        S_SHOT: begin
          r_tgt_en <= 1'b1;
          r_tor_en <= 1'b1;
          if (collision) begin
            r_won <= 1'b1;
            if (r_score != '1) begin
              r_score <= r_score + SCORE_WIDTH'(1);
            end
            r_state <= S_END_START;
          end else if (!sprite_target_within_screen) begin
            r_state <= S_END_START;
          end else if (!sprite_torpedo_within_screen) begin
            r_state <= S_FLY;
          end
        end
        S_END_START: begin
          r_tgt_en      <= 1'b0;
          r_tor_en      <= 1'b0;
          r_timer_start <= 1'b1;
          r_seen_run    <= 1'b0;
          r_idle_once   <= 1'b0;
          r_state       <= S_END_WAIT;
        end
        S_END_WAIT: begin
          r_tgt_en <= 1'b0;
          r_tor_en <= 1'b0;
          // Exit on running 1->0, or after two consecutive idle samples
          // when the timer never reports running.
          if (end_of_game_timer_running) begin
            r_seen_run  <= 1'b1;
            r_idle_once <= 1'b0;
          end else if (r_seen_run || r_idle_once) begin
            r_state <= S_START;
          end else begin
            r_idle_once <= 1'b1;
          end
        end
        default: begin
          r_state <= S_START;
        end
      endcase
    end
  end

  assign sprite_target_write_xy       = r_tgt_wxy;
  assign sprite_target_write_dxy      = r_tgt_wdxy;
  assign sprite_target_enable_update  = r_tgt_en;
  assign sprite_torpedo_write_xy      = r_tor_wxy;
  assign sprite_torpedo_write_dxy     = r_tor_wdxy;
  assign sprite_torpedo_enable_update = r_tor_en;
  assign game_won                     = r_won;
  assign end_of_game_timer_start      = r_timer_start;
  assign shots_left                   = r_shots;
  assign score                        = r_score;

endmodule

// File: tb/tb_game_round_controller.sv
// Directed self-checking bench for game_round_controller.
module tb_game_round_controller;

  logic       clk;
  logic       reset;
  logic       key;
  logic       tgt_wxy, tgt_wdxy, tgt_en;
  logic       tor_wxy, tor_wdxy, tor_en;
  logic       tgt_in, tor_in;
  logic       collision;
  logic       won;
  logic       tstart;
  logic       running;
  logic [2:0] shots;
  logic [7:0] score;
  logic [7:0] flags;

  int n_cmp;
  int n_bad;
  int tor_writes;

  game_round_controller #(
    .N_SHOTS     (3),
    .SHOT_WIDTH  (3),
    .SCORE_WIDTH (8)
  ) dut (
    .clk                          (clk),
    .reset                        (reset),
    .key                          (key),
    .sprite_target_write_xy       (tgt_wxy),
    .sprite_target_write_dxy      (tgt_wdxy),
    .sprite_target_enable_update  (tgt_en),
    .sprite_torpedo_write_xy      (tor_wxy),
    .sprite_torpedo_write_dxy     (tor_wdxy),
    .sprite_torpedo_enable_update (tor_en),
    .sprite_target_within_screen  (tgt_in),
    .sprite_torpedo_within_screen (tor_in),
    .collision                    (collision),
    .game_won                     (won),
    .end_of_game_timer_start      (tstart),
    .end_of_game_timer_running    (running),
    .shots_left                   (shots),
    .score                        (score)
  );

  // {tgt_wxy, tgt_wdxy, tgt_en, tor_wxy, tor_wdxy, tor_en, game_won, timer_start}
  assign flags = {tgt_wxy, tgt_wdxy, tgt_en, tor_wxy, tor_wdxy, tor_en, won, tstart};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Torpedo launches, counted at the edge that would consume the pulse.
  always @(posedge clk) if (tor_wxy) tor_writes++;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Waits for the start-of-round target write pulse; returns 99 on timeout.
  task automatic wait_round_start(output int cyc);
    cyc = 99;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (tgt_wxy) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic timer_handshake;
    running = 1'b1;
    tick(4);
    running = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0; key = 1'b0; tgt_in = 1'b1; tor_in = 1'b1;
    collision = 1'b0; running = 1'b0;
    tick(3);
    n_cmp++;
    if (flags !== 8'h00 || shots !== 3'd0 || score !== 8'd0) begin
      n_bad++;
      $display("FAIL reset_hold flags=%b shots=%0d score=%0d want 00000000/0/0", flags, shots, score);
    end
    reset = 1'b1;
    tick(1);
    n_cmp++;
    if (flags !== 8'b11000000 || shots !== 3'd3) begin
      n_bad++;
      $display("FAIL reset_cycle1 flags=%b shots=%0d want 11000000/3", flags, shots);
    end
    tick(1);
    n_cmp++;
    if (flags !== 8'b00000000) begin
      n_bad++;
      $display("FAIL reset_cycle2 flags=%b want 00000000", flags);
    end
    tick(1);
    n_cmp++;
    if (flags !== 8'b00100000) begin
      n_bad++;
      $display("FAIL reset_cycle3 flags=%b want 00100000", flags);
    end
  endtask

  task automatic test_fire_hit;
    int w0;
    int cyc;
    w0 = tor_writes;
    key = 1'b1;
    tick(3);
    n_cmp++;
    if (flags !== 8'b00111000 || shots !== 3'd2) begin
      n_bad++;
      $display("FAIL fire_launch flags=%b shots=%0d want 00111000/2", flags, shots);
    end
    key = 1'b0;
    tick(1);
    n_cmp++;
    if (flags !== 8'b00100000) begin
      n_bad++;
      $display("FAIL fire_settle flags=%b want 00100000", flags);
    end
    tick(1);
    n_cmp++;
    if (flags !== 8'b00100100) begin
      n_bad++;
      $display("FAIL fire_shot flags=%b want 00100100", flags);
    end
    tick(5);
    collision = 1'b1;
    tick(1);
    collision = 1'b0;
    n_cmp++;
    if (flags !== 8'b00100110 || score !== 8'd1) begin
      n_bad++;
      $display("FAIL hit_score flags=%b score=%0d want 00100110/1", flags, score);
    end
    tick(1);
    n_cmp++;
    if (flags !== 8'b00000011 || (tor_writes - w0) !== 1) begin
      n_bad++;
      $display("FAIL hit_timer flags=%b writes=%0d want 00000011/1", flags, tor_writes - w0);
    end
    timer_handshake();
    wait_round_start(cyc);
    n_cmp++;
    if (cyc > 10 || won !== 1'b0 || shots !== 3'd3 || score !== 8'd1) begin
      n_bad++;
      $display("FAIL hit_restart cyc=%0d won=%b shots=%0d score=%0d want <=10/0/3/1", cyc, won, shots, score);
    end
    tick(2);
  endtask

  task automatic test_out_of_shots;
    int w0;
    int cyc;
    w0 = tor_writes;
    for (int k = 0; k < 3; k++) begin
      key = 1'b1;
      tick(3);
      n_cmp++;
      if (tor_wxy !== 1'b1 || shots !== 3'(2 - k)) begin
        n_bad++;
        $display("FAIL shot_%0d wxy=%b shots=%0d want 1/%0d", k, tor_wxy, shots, 2 - k);
      end
      key = 1'b0;
      tick(2);
      tor_in = 1'b0;
      tick(1);
      tor_in = 1'b1;
    end
    key = 1'b1;
    tick(3);
    n_cmp++;
    if (tor_wxy !== 1'b0 || shots !== 3'd0) begin
      n_bad++;
      $display("FAIL shot_empty wxy=%b shots=%0d want 0/0", tor_wxy, shots);
    end
    tick(3);
    key = 1'b0;
    n_cmp++;
    if ((tor_writes - w0) !== 3) begin
      n_bad++;
      $display("FAIL shot_count got=%0d want 3", tor_writes - w0);
    end
    tgt_in = 1'b0;
    tick(1);
    tgt_in = 1'b1;
    tick(1);
    n_cmp++;
    if (tstart !== 1'b1 || won !== 1'b0 || score !== 8'd1) begin
      n_bad++;
      $display("FAIL miss_end tstart=%b won=%b score=%0d want 1/0/1", tstart, won, score);
    end
    timer_handshake();
    wait_round_start(cyc);
    n_cmp++;
    if (cyc > 10 || shots !== 3'd3) begin
      n_bad++;
      $display("FAIL miss_restart cyc=%0d shots=%0d want <=10/3", cyc, shots);
    end
    tick(2);
  endtask

  task automatic test_coincident;
    int cyc;
    key = 1'b1;
    tick(3);
    key = 1'b0;
    tick(2);
    collision = 1'b1;
    tgt_in = 1'b0;
    tick(1);
    collision = 1'b0;
    tgt_in = 1'b1;
    n_cmp++;
    if (score !== 8'd2 || won !== 1'b1) begin
      n_bad++;
      $display("FAIL coincident score=%0d won=%b want 2/1", score, won);
    end
    tick(1);
    n_cmp++;
    if (tstart !== 1'b1) begin
      n_bad++;
      $display("FAIL coincident_timer tstart=%b want 1", tstart);
    end
    timer_handshake();
    wait_round_start(cyc);
    n_cmp++;
    if (cyc > 10 || won !== 1'b0 || score !== 8'd2) begin
      n_bad++;
      $display("FAIL coincident_restart cyc=%0d won=%b score=%0d want <=10/0/2", cyc, won, score);
    end
    tick(2);
  endtask

  task automatic test_key_hold_glitch;
    int w0;
    int cyc;
    w0 = tor_writes;
    key = 1'b1;
    tick(3);
    n_cmp++;
    if (shots !== 3'd2) begin
      n_bad++;
      $display("FAIL hold_first shots=%0d want 2", shots);
    end
    tick(2);
    tor_in = 1'b0;
    tick(1000);
    n_cmp++;
    if ((tor_writes - w0) !== 1 || shots !== 3'd2) begin
      n_bad++;
      $display("FAIL hold_repeat writes=%0d shots=%0d want 1/2", tor_writes - w0, shots);
    end
    key = 1'b0;
    tick(5);
    w0 = tor_writes;
    #3 key = 1'b1;
    #8 key = 1'b0;
    tick(10);
    n_cmp++;
    if ((tor_writes - w0) > 1) begin
      n_bad++;
      $display("FAIL glitch writes=%0d want <=1", tor_writes - w0);
    end
    tor_in = 1'b1;
    tgt_in = 1'b0;
    tick(1);
    tgt_in = 1'b1;
    tick(1);
    n_cmp++;
    if (tstart !== 1'b1) begin
      n_bad++;
      $display("FAIL glitch_end tstart=%b want 1", tstart);
    end
    // Timer never runs: the idle fallback restarts the round.
    wait_round_start(cyc);
    n_cmp++;
    if (cyc !== 3 || shots !== 3'd3) begin
      n_bad++;
      $display("FAIL idle_exit cyc=%0d shots=%0d want 3/3", cyc, shots);
    end
    tick(2);
  endtask

  task automatic test_reset_midflight;
    key = 1'b1;
    tick(3);
    key = 1'b0;
    tick(2);
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if (flags !== 8'h00 || shots !== 3'd0 || score !== 8'd0) begin
      n_bad++;
      $display("FAIL reset_shot flags=%b shots=%0d score=%0d want 00000000/0/0", flags, shots, score);
    end
    tick(1);
    reset = 1'b1;
    tick(1);
    n_cmp++;
    if (flags !== 8'b11000000 || shots !== 3'd3 || score !== 8'd0) begin
      n_bad++;
      $display("FAIL reset_shot_restart flags=%b shots=%0d score=%0d want 11000000/3/0", flags, shots, score);
    end
    tick(2);
    tgt_in = 1'b0;
    tick(1);
    tgt_in = 1'b1;
    tick(2);
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if (flags !== 8'h00 || shots !== 3'd0) begin
      n_bad++;
      $display("FAIL reset_wait flags=%b shots=%0d want 00000000/0", flags, shots);
    end
    tick(1);
    reset = 1'b1;
    tick(1);
    n_cmp++;
    if (flags !== 8'b11000000 || shots !== 3'd3) begin
      n_bad++;
      $display("FAIL reset_wait_restart flags=%b shots=%0d want 11000000/3", flags, shots);
    end
    tick(2);
  endtask

  task automatic test_saturation;
    int cyc;
    int exp_score;
    for (int n = 1; n <= 256; n++) begin
      key = 1'b1;
      tick(3);
      key = 1'b0;
      tick(2);
      collision = 1'b1;
      tick(1);
      collision = 1'b0;
      exp_score = (n > 255) ? 255 : n;
      if (n == 1 || n == 254 || n == 255 || n == 256) begin
        n_cmp++;
        if (score !== 8'(exp_score)) begin
          n_bad++;
          $display("FAIL saturate_%0d score=%0d want %0d", n, score, exp_score);
        end
      end
      tick(1);
      wait_round_start(cyc);
      if (cyc == 99) begin
        n_cmp++;
        n_bad++;
        $display("FAIL saturate_restart_%0d timeout want pulse", n);
        break;
      end
      tick(2);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    tor_writes = 0;
    test_reset();
    test_fire_hit();
    test_out_of_shots();
    test_coincident();
    test_key_hold_glitch();
    test_reset_midflight();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/game_round_controller.md
Name: game_round_controller

Overview:
Master sequencer for the target/torpedo shooting game. It launches the target sprite, fires up to N_SHOTS torpedoes per target pass on key presses, and tracks hits and misses. It keeps a saturating score and starts the end-of-round timer. It sits beside the two game_sprite_top instances, game_overlap and game_timer, and drives their write and enable controls plus the mixer's game_won.

Parameters:
N_SHOTS, 3, torpedoes available per target pass (1..7)
SHOT_WIDTH, 3, width of shots_left counter
SCORE_WIDTH, 8, width of score counter (saturates at all-ones)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-low reset (0 = reset)
key  in  1  fire button, asynchronous, 1 = pressed
sprite_target_write_xy  out  1  one-cycle pulse: load target x/y
sprite_target_write_dxy  out  1  one-cycle pulse: load target dx/dy
sprite_target_enable_update  out  1  target motion enable
sprite_torpedo_write_xy  out  1  one-cycle pulse: load torpedo x/y
sprite_torpedo_write_dxy  out  1  one-cycle pulse: load torpedo dx/dy
sprite_torpedo_enable_update  out  1  torpedo motion enable
sprite_target_within_screen  in  1  target on screen
sprite_torpedo_within_screen  in  1  torpedo on screen
collision  in  1  registered overlap flag from game_overlap
game_won  out  1  level: last round ended in a hit
end_of_game_timer_start  out  1  one-cycle pulse
end_of_game_timer_running  in  1  timer busy
shots_left  out  SHOT_WIDTH  remaining torpedoes this pass
score  out  SCORE_WIDTH  total hits

Behaviour:
- All outputs are registered. Reset values: every pulse and enable output is 0, game_won=0, shots_left=0, score=0, state=S_START. Reset may be asserted in any state and aborts immediately, including mid-flight and during the timer wait.
- Key input: 2-flop synchronizer, then a rising-edge detector. fire = one cycle per press; holding the key gives no repeat. Edge latency is 3 cycles from the key pin.
- S_START (1 cycle):
  - pulse both target write_xy and write_dxy;
  - shots_left <= N_SHOTS; game_won <= 0;
  - -> S_TGT_SETTLE.
- S_TGT_SETTLE (1 cycle): no enables; lets within_screen reflect the new position; -> S_FLY.
- S_FLY: target enable_update=1, torpedo enable=0.
  - If target_within_screen=0 -> S_END_START (miss).
  - Else if fire and shots_left!=0: pulse torpedo write_xy and write_dxy; shots_left decrements; -> S_TOR_SETTLE.
  - A fire with shots_left=0 is ignored.
- S_TOR_SETTLE (1 cycle): target enable stays 1; torpedo within_screen and collision are ignored; -> S_SHOT.
- S_SHOT: both enables 1. Priority when events coincide: collision > target off-screen > torpedo off-screen.
  - collision=1: game_won <= 1; score increments, saturating at 2^SCORE_WIDTH-1; -> S_END_START.
  - target_within_screen=0 -> S_END_START (miss).
  - torpedo_within_screen=0 -> S_FLY. The target keeps flying, and a further fire is allowed if shots_left!=0.
  - fire during S_SHOT is ignored (one torpedo in flight at a time).
- S_END_START (1 cycle): both enables 0; end_of_game_timer_start=1; -> S_END_WAIT.
- S_END_WAIT: enables 0. Leaves only after seeing end_of_game_timer_running=1 followed by 0, then -> S_START. A running flag that never asserts is tolerated: S_END_WAIT also exits once running=0 has been sampled for 2 consecutive cycles.
- game_won holds its value through S_END_* and clears in S_START. score is never cleared except by reset.
- Write pulses never overlap enable_update=1 of the same sprite in the same cycle.

Decomposition:
- Shared package game_round_pkg holds:
  - the state encoding, as localparams S_START..S_END_WAIT in a 3-bit one-hot-free binary;
  - SHOT_WIDTH/SCORE_WIDTH defaults.
- One natural sub-module: game_key_edge (synchronizer plus rising-edge detector, asynchronous active-low reset), reusable for other buttons.

Test Plan:
- Reset release -> cycle 1 target write_xy=write_dxy=1, shots_left=3; cycle 3 target enable=1; all other outputs 0.
- Key press in S_FLY, collision raised 10 cycles later -> exactly one torpedo write pulse, shots_left=2, then score=1, game_won=1, timer_start pulse one cycle after collision.
- Three torpedoes leave the screen without a hit, then a fourth key press -> shots_left 3->2->1->0, no fourth torpedo write, and a miss when the target goes off-screen (game_won=0, score unchanged).
- Collision and target off-screen in the same cycle -> treated as a hit (score+1, game_won=1).
- Key held high for 1000 cycles -> a single fire; an 8 ns glitch shorter than a clock period produces no fire or a single fire, never two.
- reset asserted during S_SHOT and S_END_WAIT -> all outputs 0 asynchronously; after release the sequence restarts at S_START with score=0; with score preset near all-ones by 256 hits, score saturates at 255.
